// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared definitions for the sequential shift-add multiplier.
//   state_t   - controller state encoding (IDLE, RUN, DONE)
//   WIDTH     - default operand width
//   cnt_width - width of the iteration counter for a given operand width
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned WIDTH = 8;

    // One extra bit so the counter can reach 'width' without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: control FSM and iteration counter for seq_mult_unit.
//   clk, reset - rising-edge clock, synchronous active-high reset
//   load, ack  - start request / result acknowledge from the consumer
//   busy       - registered, high while in RUN
//   readyR     - registered, high while in DONE
//   capture    - operands are sampled into the datapath this edge
//   step       - datapath performs one shift-add step this edge
//   commit     - this edge's step is the last; result goes to R
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned width = WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic ack,
    output logic busy,
    output logic readyR,
    output logic capture,
    output logic step,
    output logic commit
);

    localparam int unsigned CW = cnt_width(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    // load is honoured in DONE as well as IDLE (implicit acknowledge).
    assign capture = load && (state == IDLE || state == DONE);
    assign step    = (state == RUN);
    assign commit  = step && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            readyR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        readyR <= 1'b1;
                    end
                end
                DONE: begin
                    if (load) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        readyR <= 1'b0;
                    end else if (ack) begin
                        state  <= IDLE;
                        readyR <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy   <= 1'b0;
                    readyR <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: unsigned sequential shift-add multiplier, one step per clock.
//   clk, reset - rising-edge clock, synchronous active-high reset
//   load       - start request; A and B sampled on the same edge
//   A, B       - multiplicand / multiplier (unsigned, width bits)
//   ack        - consumer acknowledge of the result
//   busy       - high while an operation is iterating
//   readyR     - high while R holds a fresh, unacknowledged product
//   R          - registered product A*B (2*width bits)
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int unsigned width = WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [width-1:0]   A,
    input  logic [width-1:0]   B,
    input  logic               ack,
    output logic               busy,
    output logic               readyR,
    output logic [2*width-1:0] R
);

    logic               capture;
    logic               step;
    logic               commit;
    logic [width-1:0]   mcand;
    logic [width-1:0]   mplr;
    logic [width-1:0]   acc;
    logic [width:0]     sum;
    logic [2*width-1:0] prod_next;

    seq_mult_ctrl #(
        .width (width)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .ack     (ack),
        .busy    (busy),
        .readyR  (readyR),
        .capture (capture),
        .step    (step),
        .commit  (commit)
    );

    // Sum is one bit wider so the carry shifts into acc instead of being lost.
    assign sum       = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    assign prod_next = (2*width)'({sum, mplr} >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            R     <= '0;
        end else if (capture) begin
            mcand <= A;
            mplr  <= B;
            acc   <= '0;
        end else if (step) begin
            acc  <= prod_next[2*width-1:width];
            mplr <= prod_next[width-1:0];
            if (commit) begin
                R <= prod_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: directed self-checking bench for seq_mult_unit (width 8).
module tb_seq_mult_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        busy;
    logic        readyR;
    logic [15:0] R;

    int vectors = 0;
    int errors  = 0;

    seq_mult_unit #(
        .width (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .A      (A),
        .B      (B),
        .ack    (ack),
        .busy   (busy),
        .readyR (readyR),
        .R      (R)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b);
        A    = a;
        B    = b;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Counts cycles with busy high (bounded); flags readyR seen during busy.
    task automatic wait_done(output int n, output bit early_ready);
        n = 0;
        early_ready = 1'b0;
        while (busy && n < 20) begin
            if (readyR) early_ready = 1'b1;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (readyR !== 1'b0) begin
            errors++;
            $display("FAIL reset_readyR: got %b want 0", readyR);
        end
        vectors++;
        if (R !== 16'h0000) begin
            errors++;
            $display("FAIL reset_R: got %h want 0000", R);
        end
    endtask

    task automatic test_basic();
        int n;
        bit early;
        do_load(8'hE9, 8'hC3);
        wait_done(n, early);
        vectors++;
        if (n !== 8) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d want 8", n);
        end
        vectors++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_ready: got %b want 0", early);
        end
        vectors++;
        if (readyR !== 1'b1 || R !== 16'hB17B) begin
            errors++;
            $display("FAIL basic_result: got readyR=%b R=%h want 1 B17B", readyR, R);
        end
        // Hold while unacknowledged, with unrelated input activity.
        A = 8'h11;
        B = 8'h22;
        tick();
        tick();
        tick();
        vectors++;
        if (readyR !== 1'b1 || busy !== 1'b0 || R !== 16'hB17B) begin
            errors++;
            $display("FAIL basic_hold: got readyR=%b busy=%b R=%h want 1 0 B17B", readyR, busy, R);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++;
        if (readyR !== 1'b0 || busy !== 1'b0 || R !== 16'hB17B) begin
            errors++;
            $display("FAIL basic_ack: got readyR=%b busy=%b R=%h want 0 0 B17B", readyR, busy, R);
        end
    endtask

    task automatic test_corners();
        int n;
        bit early;
        do_load(8'hFF, 8'hFF);
        wait_done(n, early);
        vectors++;
        if (n !== 8 || readyR !== 1'b1 || R !== 16'hFE01) begin
            errors++;
            $display("FAIL corner_max: got n=%0d readyR=%b R=%h want 8 1 FE01", n, readyR, R);
        end
        // load together with ack in DONE starts a new operation.
        ack = 1'b1;
        do_load(8'h00, 8'hA5);
        ack = 1'b0;
        vectors++;
        if (busy !== 1'b1 || readyR !== 1'b0 || R !== 16'hFE01) begin
            errors++;
            $display("FAIL corner_restart: got busy=%b readyR=%b R=%h want 1 0 FE01", busy, readyR, R);
        end
        wait_done(n, early);
        vectors++;
        if (n !== 8 || readyR !== 1'b1 || R !== 16'h0000) begin
            errors++;
            $display("FAIL corner_zero: got n=%0d readyR=%b R=%h want 8 1 0000", n, readyR, R);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_ignore_inputs();
        int n;
        do_load(8'hE9, 8'hC3);
        n = 0;
        while (busy && n < 20) begin
            if (n < 6) begin
                load = 1'b1;
                ack  = 1'b1;
                A    = 8'(8'h37 + n);
                B    = 8'(8'hF0 - n);
            end else begin
                load = 1'b0;
                ack  = 1'b0;
            end
            n++;
            tick();
        end
        load = 1'b0;
        ack  = 1'b0;
        vectors++;
        if (n !== 8) begin
            errors++;
            $display("FAIL ignore_busy_len: got %0d want 8", n);
        end
        vectors++;
        if (readyR !== 1'b1 || R !== 16'hB17B) begin
            errors++;
            $display("FAIL ignore_result: got readyR=%b R=%h want 1 B17B", readyR, R);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit early;
        do_load(8'h5A, 8'h77);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || readyR !== 1'b0 || R !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%b readyR=%b R=%h want 0 0 0000", busy, readyR, R);
        end
        do_load(8'h12, 8'h34);
        wait_done(n, early);
        vectors++;
        if (n !== 8 || early !== 1'b0 || readyR !== 1'b1 || R !== 16'h03A8) begin
            errors++;
            $display("FAIL midrun_reload: got n=%0d early=%b readyR=%b R=%h want 8 0 1 03A8",
                     n, early, readyR, R);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit early;
        // Still in DONE from the previous task.
        do_load(8'h03, 8'h05);
        vectors++;
        if (busy !== 1'b1 || readyR !== 1'b0 || R !== 16'h03A8) begin
            errors++;
            $display("FAIL b2b_start: got busy=%b readyR=%b R=%h want 1 0 03A8", busy, readyR, R);
        end
        wait_done(n, early);
        vectors++;
        if (n !== 8 || readyR !== 1'b1 || R !== 16'h000F) begin
            errors++;
            $display("FAIL b2b_result: got n=%0d readyR=%b R=%h want 8 1 000F", n, readyR, R);
        end
        ack = 1'b1;
        tick();
        vectors++;
        if (readyR !== 1'b0 || busy !== 1'b0 || R !== 16'h000F) begin
            errors++;
            $display("FAIL b2b_ack: got readyR=%b busy=%b R=%h want 0 0 000F", readyR, busy, R);
        end
        // ack in IDLE has no effect.
        tick();
        tick();
        ack = 1'b0;
        vectors++;
        if (readyR !== 1'b0 || busy !== 1'b0 || R !== 16'h000F) begin
            errors++;
            $display("FAIL idle_ack: got readyR=%b busy=%b R=%h want 0 0 000F", readyR, busy, R);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_inputs();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_unit.md
SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 Parameter: width, default 8, operand width in bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-004 Port reset: input, 1 bit, synchronous active-high reset.
REQ-005 Port load: input, 1 bit, start request; A and B are sampled on the same edge.
REQ-006 Port A: input, width bits, multiplicand (unsigned).
REQ-007 Port B: input, width bits, multiplier (unsigned).
REQ-008 Port ack: input, 1 bit, consumer acknowledge of the result.
REQ-009 Port busy: output, 1 bit, high while an iteration is in progress.
REQ-010 Port readyR: output, 1 bit, high while R holds a fresh, unacknowledged product.
REQ-011 Port R: output, 2*width bits, registered unsigned product A*B.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE. All outputs SHALL be Moore (registered) outputs.
REQ-013 In IDLE, load=1 at edge k SHALL capture A into mcand, B into mplr, clear acc and clear the iteration counter cnt, then enter RUN.
REQ-014 In RUN, each edge SHALL perform one shift-add step:
- sum = acc + (mplr[0] ? mcand : 0), computed width+1 bits wide.
- {acc, mplr} = {sum, mplr} >> 1, so the carry is not lost.
- cnt increments by 1.
REQ-015 RUN SHALL last exactly width edges. On edge k+width the block SHALL load R with {acc, mplr} of the final step and enter DONE.
REQ-016 busy SHALL equal (state==RUN), i.e. high for exactly width cycles, following edges k through k+width-1.
REQ-017 readyR SHALL equal (state==DONE) and SHALL first be high after edge k+width.
REQ-018 In DONE, ack=1 with load=0 SHALL return the FSM to IDLE; readyR drops on that edge.
REQ-019 In DONE, load=1 SHALL start a new operation exactly as in IDLE (an implicit ack). This applies regardless of ack.
REQ-020 In RUN, load and ack SHALL be ignored. A and B SHALL NOT affect an operation in progress.
REQ-021 ack in IDLE SHALL be ignored.
REQ-022 R SHALL change only on entry to DONE and SHALL hold its last value through IDLE and the following RUN.
REQ-023 cnt SHALL be ceil(log2(width))+1 bits wide and SHALL NOT wrap within an operation.
REQ-024 The result SHALL be exact for all operands, including 0 and 2^width-1 (max product (2^width-1)^2 fits in 2*width bits).

Reset
REQ-025 reset=1 at an edge SHALL force state=IDLE and set busy=0, readyR=0, R=0, acc=0, mplr=0, mcand=0 and cnt=0, regardless of state or load.
REQ-026 A reset during RUN SHALL abort the operation with no readyR pulse. load SHALL be accepted from the first edge after reset deasserts.

Structure
REQ-027 A shared package seq_mult_pkg SHALL hold:
- the state typedef (IDLE, RUN, DONE);
- the default WIDTH constant;
- the function deriving the cnt width.
REQ-028 Control SHALL be split into one sub-module, seq_mult_ctrl, containing the FSM and cnt. It produces busy, readyR and the step/capture/commit strobes.
REQ-029 The datapath registers (mcand, mplr, acc, R) SHALL remain in seq_mult_unit.

Verification
REQ-030 Reset, then load pulse with A=0xE9, B=0xC3 -> busy high exactly 8 cycles; readyR high after the 9th edge from load; R=0xB17B held until ack.
REQ-031 A=0xFF, B=0xFF -> R=0xFE01. Then A=0x00, B=0xA5 -> R=0x0000; readyR asserted both times.
REQ-032 load pulses and A/B changes during RUN -> ignored; R equals the product of the first operands; busy length unchanged.
REQ-033 reset asserted on the 4th RUN cycle -> next cycle busy=0, readyR=0, R=0; a new load then completes normally.
REQ-034 In DONE, load=1 with ack=0 and A=0x03, B=0x05 -> immediate new RUN; after 8 cycles R=0x000F. Separately, ack alone in DONE -> IDLE, readyR low, R retained.
